// File: rtl/motion_bbox_pkg.sv
// Shared constants and types for the motion-segmentation pipeline
// (dilator, bounding-box extractor, overlay).
//   - Image geometry defaults and coordinate/count widths
//   - Bounding-box FSM state encoding
//   - Accumulator record and its cleared value
//   - Saturating pixel-count adder
package motion_bbox_pkg;

    localparam int unsigned H_IMG_RES = 640;
    localparam int unsigned V_IMG_RES = 480;
    localparam int unsigned COORD_W   = 11;
    localparam int unsigned COUNT_W   = 20;
    localparam int unsigned RUN_W     = 4;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACCUM    = 2'd1,
        LATCH    = 2'd2
    } state_t;

    typedef struct packed {
        logic               any;
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] ymax;
        logic [COUNT_W-1:0] count;
    } acc_t;

    // Mins start at all-ones and maxes at zero so the first qualified
    // run overwrites both.
    localparam acc_t ACC_CLEAR = '{
        any:   1'b0,
        xmin:  '1,
        xmax:  '0,
        ymin:  '1,
        ymax:  '0,
        count: '0
    };

    function automatic logic [COUNT_W-1:0] sat_add(
        input logic [COUNT_W-1:0] a,
        input logic [COUNT_W-1:0] b
    );
        logic [COUNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[COUNT_W] ? '1 : sum[COUNT_W-1:0];
    endfunction

endpackage

// File: rtl/motion_bbox_run_qualifier.sv
// Per-line horizontal run qualifier.
// Tracks the length of the current run of 1-pixels (saturating at
// MIN_RUN) and flags when a run first reaches MIN_RUN and when it
// continues beyond that. Runs restart at x==0 and never span lines.
// Ports:
//   clk, rst    pixel clock, synchronous active-high reset
//   x           horizontal position of the current pixel
//   active      current pixel lies in the active image area
//   in_pix      mask pixel (ignored when not active)
//   qual_first  run reached MIN_RUN on this pixel
//   qual_cont   run already qualified, this pixel extends it
//   run_start   x of the first pixel of the current run
//   cur_x       x of the current pixel
module motion_bbox_run_qualifier
    import motion_bbox_pkg::*;
#(
    parameter int unsigned MIN_RUN = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] x,
    input  logic               active,
    input  logic               in_pix,
    output logic               qual_first,
    output logic               qual_cont,
    output logic [COORD_W-1:0] run_start,
    output logic [COORD_W-1:0] cur_x
);

    localparam logic [RUN_W-1:0] MIN_RUN_L = RUN_W'(MIN_RUN);

    logic [RUN_W-1:0]   run_len_q;
    logic [RUN_W-1:0]   run_len_d;
    logic [RUN_W-1:0]   eff_len;
    logic [COORD_W-1:0] start_q;
    logic               pix;

    always_comb begin
        pix        = active & in_pix;
        // A new line wipes the run before this pixel is evaluated.
        eff_len    = (x == '0) ? '0 : run_len_q;
        run_len_d  = '0;
        qual_first = 1'b0;
        qual_cont  = 1'b0;
        run_start  = (eff_len == '0) ? x : start_q;
        cur_x      = x;
        if (pix) begin
            if (eff_len == MIN_RUN_L) begin
                run_len_d = MIN_RUN_L;
                qual_cont = 1'b1;
            end else begin
                run_len_d  = eff_len + 1'b1;
                qual_first = (eff_len == MIN_RUN_L - 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_len_q <= '0;
            start_q   <= '0;
        end else begin
            run_len_q <= run_len_d;
            if (pix && eff_len == '0) begin
                start_q <= x;
            end
        end
    end

endmodule

// File: rtl/motion_bbox.sv
// Frame-level bounding-box extractor for the dilated motion mask.
// Filters short horizontal runs, accumulates extent and pixel count of
// the remaining foreground, and publishes one registered box per frame.
// Ports:
//   clk, rst     pixel clock, synchronous active-high reset
//   hpos, vpos   raster counters; mask row lags vpos by V_OFFSET lines
//   in_pix       dilated mask pixel
//   bbox_xmin/xmax/ymin/ymax  box of last completed frame (0 if empty)
//   pix_count    qualified pixel count of last frame, saturating
//   bbox_valid   last frame reached MIN_COUNT qualified pixels
//   frame_done   one-cycle pulse coincident with the output update
module motion_bbox #(
    parameter int unsigned H_IMG_RES = motion_bbox_pkg::H_IMG_RES,
    parameter int unsigned V_IMG_RES = motion_bbox_pkg::V_IMG_RES,
    parameter int unsigned V_OFFSET  = 3,
    parameter int unsigned MIN_RUN   = 3,
    parameter int unsigned MIN_COUNT = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [motion_bbox_pkg::COORD_W-1:0] hpos,
    input  logic [motion_bbox_pkg::COORD_W-1:0] vpos,
    input  logic                                in_pix,
    output logic [motion_bbox_pkg::COORD_W-1:0] bbox_xmin,
    output logic [motion_bbox_pkg::COORD_W-1:0] bbox_xmax,
    output logic [motion_bbox_pkg::COORD_W-1:0] bbox_ymin,
    output logic [motion_bbox_pkg::COORD_W-1:0] bbox_ymax,
    output logic [motion_bbox_pkg::COUNT_W-1:0] pix_count,
    output logic                                bbox_valid,
    output logic                                frame_done
);

    import motion_bbox_pkg::*;

    localparam logic [COORD_W-1:0] H_RES     = COORD_W'(H_IMG_RES);
    localparam logic [COORD_W-1:0] V_RES     = COORD_W'(V_IMG_RES);
    localparam logic [COORD_W-1:0] V_OFF     = COORD_W'(V_OFFSET);
    localparam logic [COUNT_W-1:0] MIN_RUN_C = COUNT_W'(MIN_RUN);
    localparam logic [COUNT_W-1:0] MIN_CNT_C = COUNT_W'(MIN_COUNT);
    localparam logic [COUNT_W-1:0] ONE_C     = COUNT_W'(1);

    state_t             state_q;
    state_t             state_d;
    acc_t               acc_q;
    acc_t               acc_d;
    logic               active;
    logic [COORD_W-1:0] y;
    logic               sof;
    logic               last_pix;
    logic               proc;
    logic               publish;
    logic               qual_first;
    logic               qual_cont;
    logic [COORD_W-1:0] run_start;
    logic [COORD_W-1:0] cur_x;

    always_comb begin
        active   = (hpos < H_RES) && (vpos < V_RES);
        y        = (vpos >= V_OFF) ? (vpos - V_OFF) : (vpos + (V_RES - V_OFF));
        sof      = active && (hpos == '0) && (y == '0);
        last_pix = active && (hpos == H_RES - 1'b1) && (y == V_RES - 1'b1);
    end

    motion_bbox_run_qualifier #(
        .MIN_RUN (MIN_RUN)
    ) u_run_qualifier (
        .clk        (clk),
        .rst        (rst),
        .x          (hpos),
        .active     (active),
        .in_pix     (in_pix),
        .qual_first (qual_first),
        .qual_cont  (qual_cont),
        .run_start  (run_start),
        .cur_x      (cur_x)
    );

    always_comb begin
        state_d = state_q;
        proc    = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                if (sof) begin
                    state_d = ACCUM;
                    proc    = 1'b1;
                end
            end
            ACCUM: begin
                proc = 1'b1;
                if (last_pix) begin
                    state_d = LATCH;
                end
            end
            LATCH:   state_d = ACCUM;
            default: state_d = WAIT_SOF;
        endcase
        // Outputs are loaded on the same edge that absorbs the last pixel
        // (from the next-state accumulators), so they and frame_done become
        // visible during the LATCH cycle; LATCH itself only clears.
        publish = (state_q == ACCUM) && last_pix;
    end

    always_comb begin
        acc_d = acc_q;
        if (proc && qual_first) begin
            acc_d.any   = 1'b1;
            acc_d.count = sat_add(acc_q.count, MIN_RUN_C);
            if (run_start < acc_q.xmin) acc_d.xmin = run_start;
            if (cur_x > acc_q.xmax)     acc_d.xmax = cur_x;
            if (y < acc_q.ymin)         acc_d.ymin = y;
            if (y > acc_q.ymax)         acc_d.ymax = y;
        end else if (proc && qual_cont) begin
            acc_d.count = sat_add(acc_q.count, ONE_C);
            if (cur_x > acc_q.xmax)     acc_d.xmax = cur_x;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_SOF;
            acc_q      <= ACC_CLEAR;
            bbox_xmin  <= '0;
            bbox_xmax  <= '0;
            bbox_ymin  <= '0;
            bbox_ymax  <= '0;
            pix_count  <= '0;
            bbox_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_done <= publish;
            if (state_q == LATCH) begin
                acc_q <= ACC_CLEAR;
            end else begin
                acc_q <= acc_d;
            end
            if (publish) begin
                if (acc_d.any) begin
                    bbox_xmin  <= acc_d.xmin;
                    bbox_xmax  <= acc_d.xmax;
                    bbox_ymin  <= acc_d.ymin;
                    bbox_ymax  <= acc_d.ymax;
                    pix_count  <= acc_d.count;
                    bbox_valid <= (acc_d.count >= MIN_CNT_C);
                end else begin
                    bbox_xmin  <= '0;
                    bbox_xmax  <= '0;
                    bbox_ymin  <= '0;
                    bbox_ymax  <= '0;
                    pix_count  <= '0;
                    bbox_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_motion_bbox.sv
// Testbench for motion_bbox on a reduced 64x48 image with blanking.
// A per-frame mask is rastered into the DUT; an independent segment-based
// model computes the expected box, which is queued when the last active
// pixel is driven and popped when frame_done is observed.
module tb_motion_bbox;

    localparam int unsigned H      = 64;
    localparam int unsigned V      = 48;
    localparam int unsigned HTOT   = 70;
    localparam int unsigned VTOT   = 52;
    localparam int unsigned VOFF   = 3;
    localparam int unsigned MINRUN = 3;
    localparam int unsigned MINCNT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hpos;
    logic [10:0] vpos;
    logic        in_pix;
    logic [10:0] bbox_xmin;
    logic [10:0] bbox_xmax;
    logic [10:0] bbox_ymin;
    logic [10:0] bbox_ymax;
    logic [19:0] pix_count;
    logic        bbox_valid;
    logic        frame_done;

    always #5 clk = ~clk;

    motion_bbox #(
        .H_IMG_RES (H),
        .V_IMG_RES (V),
        .V_OFFSET  (VOFF),
        .MIN_RUN   (MINRUN),
        .MIN_COUNT (MINCNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hpos       (hpos),
        .vpos       (vpos),
        .in_pix     (in_pix),
        .bbox_xmin  (bbox_xmin),
        .bbox_xmax  (bbox_xmax),
        .bbox_ymin  (bbox_ymin),
        .bbox_ymax  (bbox_ymax),
        .pix_count  (pix_count),
        .bbox_valid (bbox_valid),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [10:0] xmin;
        logic [10:0] xmax;
        logic [10:0] ymin;
        logic [10:0] ymax;
        logic [19:0] count;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    bit   mask [0:V-1][0:H-1];
    int   checks   = 0;
    int   failures = 0;

    task automatic clear_mask();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                mask[y][x] = 1'b0;
    endtask

    task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                mask[y][x] = 1'b1;
    endtask

    // Finds maximal horizontal segments and credits those of length >= MINRUN.
    function automatic exp_t model();
        exp_t e;
        int   any = 0;
        int   cnt = 0;
        int   x0 = 2047, x1 = 0, y0 = 2047, y1 = 0;
        for (int y = 0; y < V; y++) begin
            int x;
            x = 0;
            while (x < H) begin
                if (mask[y][x]) begin
                    int s;
                    s = x;
                    while (x < H && mask[y][x]) x++;
                    if (x - s >= MINRUN) begin
                        any = 1;
                        cnt += x - s;
                        if (s < x0)     x0 = s;
                        if (x - 1 > x1) x1 = x - 1;
                        if (y < y0)     y0 = y;
                        if (y > y1)     y1 = y;
                    end
                end else begin
                    x++;
                end
            end
        end
        if (any == 0) begin
            e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0; e.count = 0; e.valid = 1'b0;
        end else begin
            e.xmin  = 11'(x0);
            e.xmax  = 11'(x1);
            e.ymin  = 11'(y0);
            e.ymax  = 11'(y1);
            e.count = 20'(cnt);
            e.valid = (cnt >= MINCNT);
        end
        return e;
    endfunction

    // Rasters one frame starting at image row 0 (vpos = VOFF) and ending after
    // the blanking tail of image row V-1 (vpos = VOFF-1 of the next pass).
    task automatic run_frame(input bit do_rst, input string name);
        exp_t e;
        exp_t want;
        bit   exp_done = 1'b0;
        bit   aborted  = 1'b0;
        e = model();
        for (int l = 0; l < VTOT; l++) begin
            for (int h = 0; h < HTOT; h++) begin
                int vp;
                int y;
                @(negedge clk);
                if (exp_done || frame_done !== 1'b0) begin
                    checks++;
                    if (frame_done !== exp_done) begin
                        failures++;
                        $display("FAIL %s frame_done: got %b expected %b (l=%0d h=%0d)",
                                 name, frame_done, exp_done, l, h);
                    end
                    if (frame_done === 1'b1) begin
                        checks++;
                        if (sb.size() == 0) begin
                            failures++;
                            $display("FAIL %s scoreboard: got frame_done expected none queued", name);
                        end else begin
                            want = sb.pop_front();
                            if (bbox_xmin !== want.xmin) begin
                                failures++;
                                $display("FAIL %s xmin: got %0d expected %0d", name, bbox_xmin, want.xmin);
                            end
                            checks++;
                            if (bbox_xmax !== want.xmax) begin
                                failures++;
                                $display("FAIL %s xmax: got %0d expected %0d", name, bbox_xmax, want.xmax);
                            end
                            checks++;
                            if (bbox_ymin !== want.ymin) begin
                                failures++;
                                $display("FAIL %s ymin: got %0d expected %0d", name, bbox_ymin, want.ymin);
                            end
                            checks++;
                            if (bbox_ymax !== want.ymax) begin
                                failures++;
                                $display("FAIL %s ymax: got %0d expected %0d", name, bbox_ymax, want.ymax);
                            end
                            checks++;
                            if (pix_count !== want.count) begin
                                failures++;
                                $display("FAIL %s pix_count: got %0d expected %0d", name, pix_count, want.count);
                            end
                            checks++;
                            if (bbox_valid !== want.valid) begin
                                failures++;
                                $display("FAIL %s bbox_valid: got %b expected %b", name, bbox_valid, want.valid);
                            end
                        end
                    end
                end
                exp_done = 1'b0;
                if (rst) begin
                    rst = 1'b0;
                    checks++;
                    if ({bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} !== 44'd0 ||
                        pix_count !== 20'd0 || bbox_valid !== 1'b0 || frame_done !== 1'b0) begin
                        failures++;
                        $display("FAIL %s mid_reset_outputs: got %0d/%0d/%0d/%0d cnt %0d v %b fd %b expected all 0",
                                 name, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax,
                                 pix_count, bbox_valid, frame_done);
                    end
                end
                vp = (l + VOFF) % VTOT;
                y  = (vp >= VOFF) ? vp - VOFF : vp + V - VOFF;
                hpos = 11'(h);
                vpos = 11'(vp);
                // Blanking is driven high to confirm it is gated off.
                in_pix = (h < H && vp < V) ? mask[y][h] : 1'b1;
                if (do_rst && l == 20 && h == 10) begin
                    rst     = 1'b1;
                    aborted = 1'b1;
                end
                if (!aborted && vp < V && y == V - 1 && h == H - 1) begin
                    exp_done = 1'b1;
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        hpos   = 11'(HTOT - 1);
        vpos   = 11'(VTOT - 1);
        in_pix = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} !== 44'd0) begin
            failures++;
            $display("FAIL reset coords: got %0d/%0d/%0d/%0d expected 0/0/0/0",
                     bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax);
        end
        checks++;
        if (pix_count !== 20'd0) begin
            failures++;
            $display("FAIL reset pix_count: got %0d expected 0", pix_count);
        end
        checks++;
        if (bbox_valid !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset flags: got valid %b done %b expected 0 0", bbox_valid, frame_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_empty();
        clear_mask();
        run_frame(1'b0, "empty");
    endtask

    task automatic test_block();
        clear_mask();
        set_rect(10, 19, 20, 29);
        run_frame(1'b0, "block");
    endtask

    task automatic test_short_runs();
        clear_mask();
        set_rect(20, 21, 5, 5);
        set_rect(40, 41, 12, 12);
        set_rect(0, 1, 30, 30);
        set_rect(50, 51, 45, 45);
        set_rect(62, 63, 47, 47);
        set_rect(33, 33, 33, 33);
        set_rect(5, 7, 0, 0);
        run_frame(1'b0, "short_runs");
    endtask

    task automatic test_line_wrap();
        clear_mask();
        set_rect(61, 63, 10, 10);
        set_rect(0, 1, 11, 11);
        run_frame(1'b0, "line_wrap");
    endtask

    task automatic test_voffset();
        clear_mask();
        set_rect(30, 33, 45, 47);
        run_frame(1'b0, "voffset");
    endtask

    task automatic test_threshold();
        clear_mask();
        set_rect(2, 10, 3, 9);
        run_frame(1'b0, "count_63");
        clear_mask();
        set_rect(40, 47, 30, 37);
        run_frame(1'b0, "count_64");
    endtask

    task automatic test_mid_reset();
        clear_mask();
        set_rect(5, 9, 5, 30);
        run_frame(1'b1, "mid_reset");
        clear_mask();
        set_rect(0, H - 1, 0, V - 1);
        run_frame(1'b0, "after_reset_full");
    endtask

    initial begin
        test_reset();
        test_empty();
        test_block();
        test_short_runs();
        test_line_wrap();
        test_voffset();
        test_threshold();
        test_mid_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d frames pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motion_bbox.md
Name: motion_bbox

Overview:
- Frame-level bounding-box extractor. Sits directly downstream of the 5x5 binary dilation stage in the motion-segmentation pipeline.
- Consumes the dilated foreground mask, streamed one pixel per clock with raster counters hpos/vpos.
- Rejects short horizontal noise runs and accumulates the extent and pixel count of the remaining foreground.
- Publishes one registered bounding box per frame to the overlay/reporting logic.

Parameters:
- H_IMG_RES, 640, active pixels per line; hpos >= H_IMG_RES is blanking.
- V_IMG_RES, 480, active lines per frame; vpos >= V_IMG_RES is blanking.
- V_OFFSET, 3, line lag of the mask relative to vpos (dilator alignment). Image row y = (vpos - V_OFFSET) mod V_IMG_RES.
- MIN_RUN, 3, minimum consecutive 1-pixels on a line for those pixels to count as foreground (1..15).
- MIN_COUNT, 64, minimum qualified pixels per frame for bbox_valid.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- hpos  in  11  horizontal raster position
- vpos  in  11  vertical raster position
- in_pix  in  1  dilated mask pixel for (hpos, y)
- bbox_xmin  out  11  leftmost qualified x of last completed frame
- bbox_xmax  out  11  rightmost qualified x
- bbox_ymin  out  11  topmost qualified y
- bbox_ymax  out  11  bottommost qualified y
- pix_count  out  20  qualified pixel count of last frame, saturating
- bbox_valid  out  1  last frame had pix_count >= MIN_COUNT
- frame_done  out  1  one-cycle pulse when outputs update

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values: all outputs 0. Accumulators cleared. FSM enters WAIT_SOF.
- Active pixel: hpos < H_IMG_RES and vpos < V_IMG_RES. When not active, in_pix is treated as 0.
- x = hpos. y = vpos - V_OFFSET if vpos >= V_OFFSET, else vpos + V_IMG_RES - V_OFFSET.
- FSM states:
  - WAIT_SOF: ignore pixels. Go to ACCUM on the cycle an active pixel has x==0, y==0; that pixel is processed.
  - ACCUM: run qualification and accumulation. On active pixel x==H_IMG_RES-1, y==V_IMG_RES-1, process it, then go to LATCH.
  - LATCH: one cycle. Copy accumulators to outputs, pulse frame_done, clear accumulators, go to ACCUM. The next frame's x=0,y=0 pixel never coincides with LATCH (blanking guaranteed).
- Run qualifier (per line):
  - run_len (4 bits) resets to 0 at x==0 before evaluating the pixel, on any 0 pixel, and outside active region.
  - On a 1 pixel, run_len increments, saturating at MIN_RUN. run_start is latched when run_len goes 0->1.
  - When run_len reaches MIN_RUN: count += MIN_RUN; xmin = min(xmin, run_start); xmax = max(xmax, x); ymin/ymax updated with y.
  - On further 1 pixels with run_len already MIN_RUN: count += 1; xmax = max(xmax, x).
  - Runs never span lines. A run still open at x==H_IMG_RES-1 is credited only if it already qualified.
- Accumulator clear state: xmin=ymin=2047, xmax=ymax=0, count=0, any=0. any is set on the first qualification.
- Output latch:
  - If any==0: all coordinates 0, pix_count 0, bbox_valid 0.
  - Otherwise: coordinates and count copied; bbox_valid = (count >= MIN_COUNT).
- Count saturates at 2^20-1.
- Latency: outputs and frame_done change exactly 1 cycle after the last active pixel of the frame. Outputs hold until the next LATCH.
- rst mid-frame: outputs zeroed, partial frame discarded, WAIT_SOF. No frame_done until a full frame completes.

Decomposition:
- Shared package: H_IMG_RES, V_IMG_RES, COORD_W=11, COUNT_W=20, FSM state encoding (WAIT_SOF, ACCUM, LATCH). The dilator and overlay use the same constants.
- Sub-module run_qualifier:
  - Inputs: x, active, in_pix.
  - Outputs: qual_first (pulse with run_start), qual_cont, current x.
  - Top holds the FSM, min/max accumulators and output registers.

Test Plan:
- Reset then one frame, mask all 0 -> frame_done 1 cycle after (x=639,y=479); all outputs 0, bbox_valid 0.
- Solid 10x10 block at x 100..109, y 50..59 -> xmin 100, xmax 109, ymin 50, ymax 59, pix_count 100, bbox_valid 1.
- Isolated 2-pixel runs scattered (MIN_RUN=3), plus one 3-pixel run at x 5..7, y 0 -> xmin 5, xmax 7, ymin 0, ymax 0, count 3, bbox_valid 0.
- Run at x 637..639 of line y=10 followed by 1s at x 0..1 of line 11 -> only line 10 credited: count 3, xmax 639, ymax 10.
- Vpos alignment, V_OFFSET=3: block at vpos 0..2 maps to y 477..479 -> ymin 477, ymax 479.
- rst asserted at y=200 mid-frame -> outputs 0 immediately; frame_done suppressed until the following full frame; that frame's box reported correctly.
